// File: rtl/ppu_pkg.sv
// Shared PPU types: one pixel is a 2-bit colour index, a tile row is 8 of them.
package ppu_pkg;

  localparam int TILE_WIDTH = 8;

  typedef logic [1:0] pixel_t;
  typedef pixel_t [TILE_WIDTH-1:0] tile_row_t;

endpackage

// File: rtl/pixel_ring_buffer.sv
// DEPTH-entry pixel ring: writes a whole tile row at once, reads one pixel.
module pixel_ring_buffer
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clr_i,
  input  logic      wr_en_i,
  input  tile_row_t wr_row_i,
  input  logic      rd_en_i,
  output pixel_t    rd_pix_o
);

  localparam int PW = $clog2(DEPTH);

  pixel_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;

  // Pointer update; both wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PW'(TILE_WIDTH);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < TILE_WIDTH; i++) begin
        mem_q[wr_ptr_q + PW'(i)] <= wr_row_i[i];
      end
    end
  end

  assign rd_pix_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: tile-row push from the fetcher, one pixel per T-cycle
// out to the mixer, fine-scroll discard armed by clear.
module bg_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       tclk_in,
  input  logic                       push_valid_in,
  input  tile_row_t                  pixels_in,
  output logic                       empty_out,
  output logic                       push_ready_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  input  logic                       pop_ena_in,
  input  logic                       clear_in,
  input  logic [2:0]                 discard_in,
  output logic                       pixel_valid_out,
  output pixel_t                     pixel_out
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int CWX = CW + 1;

  logic [CW-1:0]  count_q;
  logic [CWX-1:0] count_ext_d;
  logic [2:0]     discard_q;
  logic           vld_q;
  pixel_t         pix_q;
  pixel_t         rd_pix;
  logic           push;
  logic           pop;

  assign empty_out      = (count_q == '0);
  assign push_ready_out = (count_q <= CW'(DEPTH - TILE_WIDTH));
  assign count_out      = count_q;

  // Clear wins over any same-cycle traffic; pop uses the pre-update count so
  // a push into an empty FIFO cannot be popped in the same cycle.
  assign push = push_valid_in & tclk_in & push_ready_out & ~clear_in;
  assign pop  = tclk_in & pop_ena_in & ~empty_out & ~clear_in;

  pixel_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .clr_i    (clear_in),
    .wr_en_i  (push),
    .wr_row_i (pixels_in),
    .rd_en_i  (pop),
    .rd_pix_o (rd_pix)
  );

  // Next count, one bit wider so an overflow or underflow is visible.
  always_comb begin
    count_ext_d = {1'b0, count_q};
    if (push) count_ext_d = count_ext_d + CWX'(TILE_WIDTH);
    if (pop)  count_ext_d = count_ext_d - CWX'(1);
  end

  // Count, discard counter and registered pixel output.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q   <= '0;
      discard_q <= '0;
      vld_q     <= 1'b0;
      pix_q     <= '0;
    end else if (clear_in) begin
      count_q   <= '0;
      discard_q <= discard_in;
      vld_q     <= 1'b0;
    end else begin
      count_q <= count_ext_d[CW-1:0];
      vld_q   <= 1'b0;
      if (pop) begin
        if (discard_q != 3'd0) begin
          discard_q <= discard_q - 3'd1;
        end else begin
          vld_q <= 1'b1;
          pix_q <= rd_pix;
        end
      end
    end
  end

  // Occupancy sanity: the ready gate should make these impossible.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (count_q <= CW'(DEPTH));
      assert (count_ext_d <= CWX'(DEPTH));
    end
  end

  assign pixel_valid_out = vld_q;
  assign pixel_out       = pix_q;

endmodule

// File: doc/bg_pixel_fifo.md
Name: bg_pixel_fifo

Overview:
Background pixel FIFO that sits directly downstream of the background fetcher and upstream of the pixel mixer/LCD output stage.
- Accepts 8-pixel tile rows (2-bit colour indices) from the fetcher in one push.
- Reports empty status back to the fetcher.
- Shifts out one pixel per T-cycle when the PPU enables popping.
- Discards the first SCX mod 8 pixels of each scanline (fine horizontal scroll) and supports a flush on line start or window trigger.

Parameters:
DEPTH, 16, storage entries in pixels; power of two, >= 8.

Ports:
clk_in  input  1  system clock (100 MHz); one clock domain.
rst_in  input  1  synchronous, active-high reset.
tclk_in  input  1  T-cycle enable strobe; all state advances only when high, except reset and clear.
push_valid_in  input  1  fetcher presents a tile row this clk cycle.
pixels_in  input  8x2  tile row; index 0 is the leftmost pixel and pops first.
empty_out  output  1  count == 0; combinational from registered count.
push_ready_out  output  1  count <= DEPTH-8; combinational from registered count.
count_out  output  $clog2(DEPTH+1)  number of stored pixels.
pop_ena_in  input  1  PPU allows a pixel to leave (mode 3, no sprite stall).
clear_in  input  1  flush all contents and arm fine-scroll discard (line start or window start).
discard_in  input  3  pixels to drop after clear; sampled on the clk cycle clear_in is high (normally SCX[2:0], 0 for window).
pixel_valid_out  output  1  one-clk pulse: pixel_out holds a visible pixel.
pixel_out  output  2  colour index of the popped pixel.

Behaviour:
- Reset: count, rd_ptr, wr_ptr and discard_cnt all 0; pixel_valid_out = 0; pixel_out = 0; empty_out = 1; push_ready_out = 1. Reset mid-line drops all contents with no further output.
- Storage: ring buffer of DEPTH 2-bit entries, rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Push:
  - Condition: push_valid_in && tclk_in && push_ready_out && !clear_in.
  - Writes pixels_in[i] to entry (wr_ptr+i) mod DEPTH for i = 0..7; wr_ptr += 8; count += 8.
  - A push while !push_ready_out is dropped silently; count is unchanged.
- Pop:
  - Condition: tclk_in && pop_ena_in && count > 0 && !clear_in, evaluated on pre-update count.
  - A push into an empty FIFO and a pop in the same cycle: the pop does not occur.
  - Pop reads entry rd_ptr; rd_ptr += 1; count -= 1.
  - If discard_cnt > 0: discard_cnt -= 1 and pixel_valid_out = 0.
  - Otherwise pixel_out <= entry and pixel_valid_out <= 1 on the next clk edge.
  - Latency: 1 clk from the popping tclk cycle to pixel_valid_out.
- pixel_valid_out: high for exactly one clk per visible pop; otherwise 0. pixel_out holds its last value when not valid.
- Simultaneous push and pop (count > 0): count_next = count + 8 - 1; both pointers advance.
- Clear:
  - Takes effect on any clk edge where clear_in is high, independent of tclk_in.
  - Sets rd_ptr = wr_ptr = count = 0 and discard_cnt = discard_in; drops any same-cycle push or pop; forces pixel_valid_out = 0.
  - A second clear while discard_cnt > 0 reloads discard_cnt.
- Discard never causes a stall: discarded pops consume T-cycles exactly like visible ones, which yields the SCX mod 8 mode-3 lengthening.
- Arithmetic: count saturation is impossible given the push_ready_out gate. Assert in simulation that count never exceeds DEPTH and never underflows.
- No state machine beyond the discard counter. The block is a pure datapath with sequential pointer/count control.

Decomposition:
- Shared package ppu_pkg: typedef logic [1:0] pixel_t; constant TILE_WIDTH = 8.
- The fetcher's pixels_out port is retyped to pixel_t [TILE_WIDTH-1:0] once the package exists.
- One sub-module is natural: pixel_ring_buffer. It holds the DEPTH x pixel_t storage with an 8-wide write port and a 1-wide read port, plus pointers.
- bg_pixel_fifo wraps it with count, discard, clear and output registers.

Test Plan:
- Reset then idle, tclk every 4 clk -> empty_out = 1, push_ready_out = 1, count_out = 0, pixel_valid_out never asserts.
- Push row {0,1,2,3,3,2,1,0} with pop_ena_in = 1, discard 0 -> 8 pixel_valid_out pulses, 1 clk after each tclk, with values 0,1,2,3,3,2,1,0; empty_out = 1 after the 8th.
- clear_in with discard_in = 3, push row {1,2,3,0,1,2,3,0}, pop continuously -> first 3 pops invisible; visible sequence 0,1,2,3,0; 8 tclk cycles consumed.
- Push, pop 2, push again (count 6 -> 14), DEPTH = 16 -> third push while count = 14 is dropped; pointers wrap correctly; output order is preserved across the wrap.
- Push and pop on the same tclk with count = 5 -> count_out = 12; popped pixel is the oldest entry.
- clear_in asserted on the same cycle as a push and a pop with count = 4 -> count_out = 0, no pixel_valid_out, push not stored. Then rst_in mid-stream -> all outputs at reset values on the next clk.
